// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared constants for the hardwired ALU instruction sequencer.
// Holds opcodes, the state encoding, alu_op bit indices and IR field positions.
package cpu_ctrl_pkg;

    // Opcodes (ir[31:27])
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    // IR field positions
    localparam int OPC_HI = 31;
    localparam int OPC_LO = 27;
    localparam int RA_HI  = 26;
    localparam int RA_LO  = 23;
    localparam int RB_HI  = 22;
    localparam int RB_LO  = 19;
    localparam int RC_HI  = 18;
    localparam int RC_LO  = 15;

    // alu_op one-hot bit indices
    localparam int ALU_ADD  = 0;
    localparam int ALU_SUB  = 1;
    localparam int ALU_AND  = 2;
    localparam int ALU_OR   = 3;
    localparam int ALU_SHR  = 4;
    localparam int ALU_SHRA = 5;
    localparam int ALU_SHL  = 6;
    localparam int ALU_ROR  = 7;
    localparam int ALU_ROL  = 8;
    localparam int ALU_NEG  = 9;
    localparam int ALU_NOT  = 10;
    localparam int ALU_MUL  = 11;
    localparam int ALU_DIV  = 12;
    localparam int NUM_ALU_OPS = 13;

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_ILL
    } state_t;

    // Execute-phase shape selected in T3
    typedef enum logic [1:0] {
        C_ILL, C_BIN, C_UNA, C_MULDIV
    } op_class_t;

    // One-hot ALU select for an opcode; zero for anything the ALU does not know
    function automatic logic [NUM_ALU_OPS-1:0] alu_onehot(input logic [4:0] opc);
        logic [NUM_ALU_OPS-1:0] sel;
        sel = '0;
        case (opc)
            OP_ADD:  sel[ALU_ADD]  = 1'b1;
            OP_SUB:  sel[ALU_SUB]  = 1'b1;
            OP_AND:  sel[ALU_AND]  = 1'b1;
            OP_OR:   sel[ALU_OR]   = 1'b1;
            OP_SHR:  sel[ALU_SHR]  = 1'b1;
            OP_SHRA: sel[ALU_SHRA] = 1'b1;
            OP_SHL:  sel[ALU_SHL]  = 1'b1;
            OP_ROR:  sel[ALU_ROR]  = 1'b1;
            OP_ROL:  sel[ALU_ROL]  = 1'b1;
            OP_NEG:  sel[ALU_NEG]  = 1'b1;
            OP_NOT:  sel[ALU_NOT]  = 1'b1;
            OP_MUL:  sel[ALU_MUL]  = 1'b1;
            OP_DIV:  sel[ALU_DIV]  = 1'b1;
            default: sel = '0;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/reg_field_decoder.sv
// reg_field_decoder: 4-to-16 one-hot decoder with enable, used for the Rin and Rout strobes.
module reg_field_decoder (
    input  logic        i_en,
    input  logic [3:0]  i_sel,
    output logic [15:0] o_onehot
);

    // Exactly one bit when enabled, none otherwise
    always_comb begin
        o_onehot = '0;
        if (i_en) o_onehot[i_sel] = 1'b1;
    end

endmodule

// File: rtl/alu_instr_sequencer.sv
// alu_instr_sequencer: hardwired fetch/execute control for register-register ALU instructions.
// Optional feature macro ALU_SEQ_MULDIV_EN: when defined, MUL/DIV are decoded (T3..T6 with
// LO/HI writeback); otherwise they take the illegal path and HIin/LOin/Zhighout stay 0.
module alu_instr_sequencer
    import cpu_ctrl_pkg::*;
(
    input  logic                   clock,
    input  logic                   clear,
    input  logic                   run,
    input  logic                   mem_ready,
    input  logic [31:0]            ir,
    output logic [15:0]            Rin,
    output logic [15:0]            Rout,
    output logic                   PCout,
    output logic                   PCin,
    output logic                   IncPC,
    output logic                   MARin,
    output logic                   MDRin,
    output logic                   MDRout,
    output logic                   IRin,
    output logic                   Yin,
    output logic                   Zin,
    output logic                   Zlowout,
    output logic                   Zhighout,
    output logic                   HIin,
    output logic                   LOin,
    output logic                   Read,
    output logic [NUM_ALU_OPS-1:0] alu_op,
    output logic                   busy,
    output logic                   instr_done,
    output logic                   illegal
);

`ifdef ALU_SEQ_MULDIV_EN
    localparam bit MULDIV_EN = 1'b1;
`else
    localparam bit MULDIV_EN = 1'b0;
`endif

    state_t                   r_state;
    state_t                   w_next;
    state_t                   w_fin;
    op_class_t                w_cls;
    logic [4:0]               w_opc;
    logic [3:0]               w_ra;
    logic [3:0]               w_rb;
    logic [3:0]               w_rc;
    logic [NUM_ALU_OPS-1:0]   w_alu;
    logic                     w_rin_en;
    logic                     w_rout_en;
    logic [3:0]               w_rout_sel;
    logic                     w_unused_ir;

    assign w_opc       = ir[OPC_HI:OPC_LO];
    assign w_ra        = ir[RA_HI:RA_LO];
    assign w_rb        = ir[RB_HI:RB_LO];
    assign w_rc        = ir[RC_HI:RC_LO];
    assign w_alu       = alu_onehot(w_opc);
    assign w_unused_ir = ^ir[RC_LO-1:0];
    // Where to go after the last state of an instruction
    assign w_fin       = run ? S_T0 : S_IDLE;

    // Classify the opcode into its execute-phase shape
    always_comb begin
        w_cls = C_ILL;
        case (w_opc)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL,
            OP_SHR, OP_SHRA, OP_SHL:  w_cls = C_BIN;
            OP_NEG, OP_NOT:           w_cls = C_UNA;
            OP_MUL, OP_DIV:           w_cls = MULDIV_EN ? C_MULDIV : C_ILL;
            default:                  w_cls = C_ILL;
        endcase
    end

    // State register
    always_ff @(posedge clock) begin
        if (clear) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next state and strobe decode; clear forces every output low
    always_comb begin
        w_next     = r_state;
        PCout      = 1'b0;
        PCin       = 1'b0;
        IncPC      = 1'b0;
        MARin      = 1'b0;
        MDRin      = 1'b0;
        MDRout     = 1'b0;
        IRin       = 1'b0;
        Yin        = 1'b0;
        Zin        = 1'b0;
        Zlowout    = 1'b0;
        Zhighout   = 1'b0;
        HIin       = 1'b0;
        LOin       = 1'b0;
        Read       = 1'b0;
        alu_op     = '0;
        busy       = 1'b0;
        instr_done = 1'b0;
        illegal    = 1'b0;
        w_rin_en   = 1'b0;
        w_rout_en  = 1'b0;
        w_rout_sel = w_rb;
        if (clear) begin
            w_next = S_IDLE;
        end else begin
            busy = (r_state != S_IDLE);
            case (r_state)
                S_IDLE: if (run) w_next = S_T0;
                S_T0: begin
                    PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
                    w_next = S_T1;
                end
                S_T1: begin
                    // PC reload repeats while waiting; Z is not updated here so it is idempotent
                    Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
                    if (mem_ready) w_next = S_T2;
                end
                S_T2: begin
                    MDRout = 1'b1; IRin = 1'b1;
                    w_next = S_T3;
                end
                S_T3: begin
                    case (w_cls)
                        C_BIN: begin
                            w_rout_en = 1'b1; Yin = 1'b1; w_next = S_T4;
                        end
                        C_UNA: begin
                            w_rout_en = 1'b1; alu_op = w_alu; Zin = 1'b1; w_next = S_T4;
                        end
                        C_MULDIV: begin
                            w_rout_en = 1'b1; w_rout_sel = w_ra; Yin = 1'b1; w_next = S_T4;
                        end
                        default: w_next = S_ILL;
                    endcase
                end
                S_T4: begin
                    if (w_cls == C_UNA) begin
                        Zlowout = 1'b1; w_rin_en = 1'b1; instr_done = 1'b1;
                        w_next = w_fin;
                    end else begin
                        w_rout_en  = 1'b1;
                        w_rout_sel = (w_cls == C_MULDIV) ? w_rb : w_rc;
                        alu_op     = w_alu;
                        Zin        = 1'b1;
                        w_next     = S_T5;
                    end
                end
                S_T5: begin
                    Zlowout = 1'b1;
                    if (w_cls == C_MULDIV) begin
                        LOin = 1'b1; w_next = S_T6;
                    end else begin
                        w_rin_en = 1'b1; instr_done = 1'b1; w_next = w_fin;
                    end
                end
                S_T6: begin
                    Zhighout = 1'b1; HIin = 1'b1; instr_done = 1'b1;
                    w_next = w_fin;
                end
                S_ILL: begin
                    illegal = 1'b1;
                    w_next  = w_fin;
                end
                default: w_next = S_IDLE;
            endcase
        end
        // Without the multiply/divide option the HI/LO path is never driven
        if (!MULDIV_EN) begin
            Zhighout = 1'b0;
            HIin     = 1'b0;
            LOin     = 1'b0;
        end
    end

    // Destination register is always Ra
    reg_field_decoder u_rin_dec (
        .i_en     (w_rin_en),
        .i_sel    (w_ra),
        .o_onehot (Rin)
    );

    // Bus source register is chosen by state
    reg_field_decoder u_rout_dec (
        .i_en     (w_rout_en),
        .i_sel    (w_rout_sel),
        .o_onehot (Rout)
    );

endmodule
